trigger_controller: RTL and testbench

Trigger arbiter and sequencer for the muon DAQ. It accepts single-cycle trigger requests from N_SRC sources, such as discriminator coincidences or test trigger emitters. It grants one request at a time using round-robin priority and issues a tagged 1-cycle trigger to the readout chain. It then holds off further triggers until readout completes or times out, followed by a fixed dead time.

---
 rtl/trigger_controller.sv | 195 +++++++++++++++++++
 tb/tb_trigger_controller.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_controller.sv
// Round-robin trigger arbiter and readout sequencer for the muon DAQ.
// Optional macro TRIGGER_CTRL_LOST_COUNT_EN adds a saturating lost-request counter.
module trigger_controller #(
  parameter int N_SRC           = 4,
  parameter int DEADTIME_CYCLES = 8,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int TAG_WIDTH       = 16
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic                     enable_i,
  input  logic [N_SRC-1:0]         src_mask_i,
  input  logic [N_SRC-1:0]         trig_req_i,
  input  logic                     readout_done_i,
  output logic                     trig_o,
  output logic [$clog2(N_SRC)-1:0] trig_src_o,
  output logic [TAG_WIDTH-1:0]     trig_tag_o,
  output logic                     busy_o,
  output logic                     timeout_o
`ifdef TRIGGER_CTRL_LOST_COUNT_EN
  ,
  output logic [15:0]              lost_count_o
`endif
);

  localparam int SRC_W = $clog2(N_SRC);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam int DT_W  = (DEADTIME_CYCLES > 1) ? $clog2(DEADTIME_CYCLES) : 1;

  localparam logic [SRC_W-1:0] PTR_RESET = SRC_W'(N_SRC - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DT_W-1:0]  DT_LAST   = DT_W'(DEADTIME_CYCLES - 1);

  // TIMEOUT is the single cycle in which timeout_o is high, ahead of the dead time.
  typedef enum logic [1:0] {
    IDLE,
    WAIT_DONE,
    TIMEOUT,
    DEADTIME
  } state_e;

  state_e               state_q, state_d;
  logic [SRC_W-1:0]     ptr_q, ptr_d;
  logic [TAG_WIDTH-1:0] tag_cnt_q, tag_cnt_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [DT_W-1:0]      dt_cnt_q, dt_cnt_d;
  logic                 trig_q, trig_d;
  logic [SRC_W-1:0]     trig_src_q, trig_src_d;
  logic [TAG_WIDTH-1:0] trig_tag_q, trig_tag_d;
  logic                 busy_q, busy_d;
  logic                 timeout_q, timeout_d;

  logic [N_SRC-1:0]     eligible;
  logic                 grant_vld;
  logic [SRC_W-1:0]     grant_idx;
  logic [SRC_W-1:0]     cand;

  assign eligible = trig_req_i & src_mask_i;

  // Round-robin search: first eligible source strictly after the last winner.
  // NOTE: every variable driven in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 1; i <= N_SRC; i++) begin
      cand = SRC_W'((int'(ptr_q) + i) % N_SRC);
      if (!grant_vld && eligible[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    tag_cnt_d  = tag_cnt_q;
    to_cnt_d   = to_cnt_q;
    dt_cnt_d   = dt_cnt_q;
    trig_d     = 1'b0;
    trig_src_d = trig_src_q;
    trig_tag_d = trig_tag_q;
    timeout_d  = 1'b0;

    case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        dt_cnt_d = '0;
        if (enable_i && grant_vld) begin
          trig_d     = 1'b1;
          trig_src_d = grant_idx;
          trig_tag_d = tag_cnt_q;
          ptr_d      = grant_idx;
          tag_cnt_d  = tag_cnt_q + TAG_WIDTH'(1);
          state_d    = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        // Done has priority over an expiry evaluated in the same cycle.
        if (readout_done_i) begin
          dt_cnt_d = '0;
          state_d  = DEADTIME;
        end else if (to_cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = TIMEOUT;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      TIMEOUT: begin
        dt_cnt_d = '0;
        state_d  = DEADTIME;
      end

      DEADTIME: begin
        if (dt_cnt_q == DT_LAST) begin
          state_d = IDLE;
        end else begin
          dt_cnt_d = dt_cnt_q + DT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      ptr_q      <= PTR_RESET;
      tag_cnt_q  <= '0;
      to_cnt_q   <= '0;
      dt_cnt_q   <= '0;
      trig_q     <= 1'b0;
      trig_src_q <= '0;
      trig_tag_q <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      tag_cnt_q  <= tag_cnt_d;
      to_cnt_q   <= to_cnt_d;
      dt_cnt_q   <= dt_cnt_d;
      trig_q     <= trig_d;
      trig_src_q <= trig_src_d;
      trig_tag_q <= trig_tag_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign trig_o     = trig_q;
  assign trig_src_o = trig_src_q;
  assign trig_tag_o = trig_tag_q;
  assign busy_o     = busy_q;
  assign timeout_o  = timeout_q;

`ifdef TRIGGER_CTRL_LOST_COUNT_EN
  logic [15:0]      lost_q, lost_d;
  logic [N_SRC-1:0] losers;
  logic             lost_now;

  // A cycle is lost when a live request exists and either nobody can be granted or some requester lost.
  always_comb begin
    losers   = eligible & ~(N_SRC'(1) << grant_idx);
    lost_now = enable_i && (|eligible) && ((state_q != IDLE) || (|losers));
    lost_d   = lost_q;
    if (lost_now && (lost_q != 16'hFFFF)) begin
      lost_d = lost_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      lost_q <= '0;
    end else begin
      lost_q <= lost_d;
    end
  end

  assign lost_count_o = lost_q;
`endif

  a_trig_single : assert property (@(posedge clk) disable iff (!aresetn) trig_o |=> !trig_o);
  a_trig_busy   : assert property (@(posedge clk) disable iff (!aresetn) trig_o |-> busy_o);
  a_to_busy     : assert property (@(posedge clk) disable iff (!aresetn) timeout_o |-> (busy_o && !trig_o));

endmodule

// File: tb/tb_trigger_controller.sv
// Directed bench for trigger_controller: table-driven cycle vectors plus hand sequences
// for timeout, mask/enable and asynchronous reset corners.
module tb_trigger_controller;

  localparam int N_SRC = 4;
  localparam int DT    = 8;
  localparam int TO    = 32;
  localparam int TW    = 2;
  localparam logic [3:0] ALL = 4'b1111;

  logic          clk;
  logic          aresetn;
  logic          enable;
  logic [3:0]    mask;
  logic [3:0]    req;
  logic          done;
  logic          trig;
  logic [1:0]    trig_src;
  logic [TW-1:0] trig_tag;
  logic          busy;
  logic          timeout;
`ifdef TRIGGER_CTRL_LOST_COUNT_EN
  logic [15:0]   lost_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  trigger_controller #(
    .N_SRC          (N_SRC),
    .DEADTIME_CYCLES(DT),
    .TIMEOUT_CYCLES (TO),
    .TAG_WIDTH      (TW)
  ) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .enable_i      (enable),
    .src_mask_i    (mask),
    .trig_req_i    (req),
    .readout_done_i(done),
    .trig_o        (trig),
    .trig_src_o    (trig_src),
    .trig_tag_o    (trig_tag),
    .busy_o        (busy),
    .timeout_o     (timeout)
`ifdef TRIGGER_CTRL_LOST_COUNT_EN
    ,
    .lost_count_o  (lost_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       en;
    logic [3:0] msk;
    logic [3:0] rq;
    logic       dn;
    logic       e_trig;
    logic [1:0] e_src;
    logic [1:0] e_tag;
    logic       e_busy;
    logic       e_to;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [3:0] m, input logic [3:0] r, input logic d);
    enable = en;
    mask   = m;
    req    = r;
    done   = d;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    step();
  endtask

  task automatic add(input logic en, input logic [3:0] m, input logic [3:0] r, input logic d,
                     input logic et, input logic [1:0] es, input logic [1:0] eg,
                     input logic eb, input logic eo);
    vec_t v;
    v.en = en; v.msk = m; v.rq = r; v.dn = d;
    v.e_trig = et; v.e_src = es; v.e_tag = eg; v.e_busy = eb; v.e_to = eo;
    vecs.push_back(v);
  endtask

  // Each record: inputs for this cycle, outputs expected in this cycle.
  task automatic run_table(input string tname);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].msk, vecs[i].rq, vecs[i].dn);
      check($sformatf("%s[%0d] trig", tname, i), 32'(trig), 32'(vecs[i].e_trig));
      check($sformatf("%s[%0d] src", tname, i), 32'(trig_src), 32'(vecs[i].e_src));
      check($sformatf("%s[%0d] tag", tname, i), 32'(trig_tag), 32'(vecs[i].e_tag));
      check($sformatf("%s[%0d] busy", tname, i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("%s[%0d] timeout", tname, i), 32'(timeout), 32'(vecs[i].e_to));
      step();
    end
    vecs.delete();
  endtask

  initial begin
    logic [1:0] sp;
    logic [1:0] tp;
    logic [1:0] s;
    aresetn = 1'b0;
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);
    do_reset();

    check("reset trig", 32'(trig), 32'd0);
    check("reset src", 32'(trig_src), 32'd0);
    check("reset tag", 32'(trig_tag), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset timeout", 32'(timeout), 32'd0);
`ifdef TRIGGER_CTRL_LOST_COUNT_EN
    check("reset lost", 32'(lost_count), 32'd0);
`endif

    // Single request from src 2, done 4 cycles after trig; src 1 hammers while busy.
    add(1, ALL, 4'b0100, 0, 0, 0, 0, 0, 0);
    add(1, ALL, 4'b0010, 0, 1, 2, 0, 1, 0);
    for (int k = 2; k <= 4; k++) add(1, ALL, 4'b0010, 0, 0, 2, 0, 1, 0);
    add(1, ALL, 4'b0010, 1, 0, 2, 0, 1, 0);
    for (int k = 0; k < DT; k++) add(1, ALL, 4'b0010, 0, 0, 2, 0, 1, 0);
    add(1, ALL, 4'b0010, 0, 0, 2, 0, 0, 0);
    add(1, ALL, 4'b0000, 1, 1, 1, 1, 1, 0);
    for (int k = 0; k < DT; k++) add(1, ALL, 4'b0000, 0, 0, 1, 1, 1, 0);
    add(1, ALL, 4'b0000, 0, 0, 1, 1, 0, 0);
    run_table("single");
`ifdef TRIGGER_CTRL_LOST_COUNT_EN
    check("lost while busy", 32'(lost_count), 32'd13);
`endif

    // Round robin between src 0 and src 3 with immediate done; tag wraps after 3.
    do_reset();
    sp = 2'd0;
    tp = 2'd0;
    for (int k = 0; k < 5; k++) begin
      s = (k % 2 == 0) ? 2'd0 : 2'd3;
      add(1, ALL, 4'b1001, 0, 0, sp, tp, 0, 0);
      add(1, ALL, 4'b0000, 1, 1, s, 2'(k), 1, 0);
      for (int j = 0; j < DT; j++) add(1, ALL, 4'b0000, 0, 0, s, 2'(k), 1, 0);
      sp = s;
      tp = 2'(k);
    end
    run_table("rr");
`ifdef TRIGGER_CTRL_LOST_COUNT_EN
    check("lost rr losers", 32'(lost_count), 32'd5);
`endif

    // Timeout without done: pulse 32 cycles after trig, idle 41 cycles after trig.
    drive(1, ALL, 4'b0100, 0);
    check("to pre busy", 32'(busy), 32'd0);
    step();
    drive(1, ALL, 4'b0000, 0);
    for (int k = 0; k <= 41; k++) begin
      if (k == 0) begin
        check("to src", 32'(trig_src), 32'd2);
        check("to tag", 32'(trig_tag), 32'd1);
      end
      check($sformatf("to[%0d] trig", k), 32'(trig), 32'(k == 0));
      check($sformatf("to[%0d] timeout", k), 32'(timeout), 32'(k == 32));
      check($sformatf("to[%0d] busy", k), 32'(busy), 32'(k <= 40));
      step();
    end

    // Done in the last counting cycle wins: no timeout pulse, idle 40 cycles after trig.
    drive(1, ALL, 4'b0100, 0);
    step();
    for (int k = 0; k <= 41; k++) begin
      drive(1, ALL, 4'b0000, k == 31);
      if (k == 0) begin
        check("race src", 32'(trig_src), 32'd2);
        check("race tag", 32'(trig_tag), 32'd2);
      end
      check($sformatf("race[%0d] trig", k), 32'(trig), 32'(k == 0));
      check($sformatf("race[%0d] timeout", k), 32'(timeout), 32'd0);
      check($sformatf("race[%0d] busy", k), 32'(busy), 32'(k <= 39));
      step();
    end

    // Masked request, disabled request, and done while idle all produce nothing.
    drive(1, 4'b1110, 4'b0001, 0);
    step();
    check("masked trig", 32'(trig), 32'd0);
    check("masked busy", 32'(busy), 32'd0);
    drive(0, ALL, 4'b1111, 0);
    step();
    check("disabled trig", 32'(trig), 32'd0);
    check("disabled busy", 32'(busy), 32'd0);
    drive(1, ALL, 4'b0000, 1);
    step();
    check("idle done busy", 32'(busy), 32'd0);

    // Enable and mask dropped mid-transaction: the event still completes.
    drive(1, ALL, 4'b0001, 0);
    step();
    check("en grant trig", 32'(trig), 32'd1);
    check("en grant src", 32'(trig_src), 32'd0);
    check("en grant tag", 32'(trig_tag), 32'd3);
    drive(0, 4'b0000, 4'b0000, 0);
    step();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("en wait[%0d] busy", k), 32'(busy), 32'd1);
      step();
    end
    drive(0, 4'b0000, 4'b0000, 1);
    check("en done busy", 32'(busy), 32'd1);
    step();
    drive(0, 4'b0000, 4'b0000, 0);
    for (int k = 0; k < DT; k++) begin
      check($sformatf("en dead[%0d] busy", k), 32'(busy), 32'd1);
      step();
    end
    check("en idle busy", 32'(busy), 32'd0);
    check("en idle trig", 32'(trig), 32'd0);

    // Asynchronous reset during the trig cycle, then priority and tag restart.
    drive(1, ALL, 4'b0010, 0);
    step();
    check("pre-rst trig", 32'(trig), 32'd1);
    check("pre-rst src", 32'(trig_src), 32'd1);
    check("pre-rst tag", 32'(trig_tag), 32'd0);
    drive(1, ALL, 4'b0000, 0);
    #2;
    aresetn = 1'b0;
    #1;
    check("rst trig", 32'(trig), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst timeout", 32'(timeout), 32'd0);
    check("rst src", 32'(trig_src), 32'd0);
    check("rst tag", 32'(trig_tag), 32'd0);
    @(negedge clk);
    aresetn = 1'b1;
    step();
    drive(1, ALL, 4'b1111, 0);
    step();
    check("post-rst trig", 32'(trig), 32'd1);
    check("post-rst src", 32'(trig_src), 32'd0);
    check("post-rst tag", 32'(trig_tag), 32'd0);
    drive(1, ALL, 4'b0000, 1);
    step();
    drive(1, ALL, 4'b0000, 0);
    repeat (DT) step();
    check("post-rst idle busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
